// File: rtl/mem_bus_pkg.sv
// rtl/mem_bus_pkg.sv - shared state encoding, widths and parity helper for the memory bus controller
package mem_bus_pkg;

    localparam int MEM_BUS_DW    = 8;
    localparam int MEM_BUS_CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS,
        ST_TURN
    } mem_bus_state_e;

    // Even parity: the stored bit makes the total count of ones even.
    function automatic logic even_parity(input logic [MEM_BUS_DW-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/mem_bus_array.sv
// rtl/mem_bus_array.sv - byte array, sync write / comb read; MEM_BUS_CTRL_PARITY_EN adds a parity bit per entry
module mem_bus_array
    import mem_bus_pkg::*;
#(
    parameter int AW = 4
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [AW-1:0]         addr_i,
    input  logic [MEM_BUS_DW-1:0] wdata_i,
    output logic [MEM_BUS_DW-1:0] rdata_o,
    output logic                  perr_o
);

`ifdef MEM_BUS_CTRL_PARITY_EN
    logic [MEM_BUS_DW:0] mem_q [0:2**AW-1];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= {even_parity(wdata_i), wdata_i};
        end
    end

    assign rdata_o = mem_q[addr_i][MEM_BUS_DW-1:0];
    assign perr_o  = mem_q[addr_i][MEM_BUS_DW] != even_parity(mem_q[addr_i][MEM_BUS_DW-1:0]);
`else
    logic [MEM_BUS_DW-1:0] mem_q [0:2**AW-1];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[addr_i];
    assign perr_o  = 1'b0;
`endif

endmodule

// File: rtl/mem_bus_ctrl.sv
// rtl/mem_bus_ctrl.sv - setup/access/turnaround sequencer for the tristate bus buffer; MEM_BUS_CTRL_PARITY_EN enables read parity check
module mem_bus_ctrl
    import mem_bus_pkg::*;
#(
    parameter int AW         = 4,
    parameter int ACC_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_we,
    input  logic [AW-1:0]         cmd_addr,
    output logic                  read,
    output logic                  write,
    output logic [MEM_BUS_DW-1:0] data_out,
    input  logic [MEM_BUS_DW-1:0] data_in,
    output logic                  rsp_valid,
    output logic [MEM_BUS_DW-1:0] rsp_data,
    output logic                  rsp_err
);

    localparam logic [MEM_BUS_CNT_W-1:0] ACC_INIT = MEM_BUS_CNT_W'(ACC_CYCLES);
    localparam logic [MEM_BUS_CNT_W-1:0] CNT_LAST = MEM_BUS_CNT_W'(1);

    mem_bus_state_e           state_q;
    logic [MEM_BUS_CNT_W-1:0] cnt_q;
    logic                     we_q;
    logic [AW-1:0]            addr_q;
    logic                     cmd_ready_q;
    logic                     read_q;
    logic                     write_q;
    logic [MEM_BUS_DW-1:0]    data_out_q;
    logic                     rsp_valid_q;
    logic [MEM_BUS_DW-1:0]    rsp_data_q;
    logic                     rsp_err_q;

    logic [AW-1:0]            arr_addr;
    logic                     arr_we;
    logic [MEM_BUS_DW-1:0]    arr_rdata;
    logic                     arr_perr;

    // In IDLE the array is addressed by the incoming command so data_out is valid from SETUP on.
    assign arr_addr = (state_q == ST_IDLE) ? cmd_addr : addr_q;
    assign arr_we   = (state_q == ST_ACCESS) && we_q && (cnt_q == CNT_LAST);

    mem_bus_array #(
        .AW(AW)
    ) u_array (
        .clk     (clk),
        .we_i    (arr_we),
        .addr_i  (arr_addr),
        .wdata_i (data_in),
        .rdata_o (arr_rdata),
        .perr_o  (arr_perr)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            cmd_ready_q <= 1'b1;
            read_q      <= 1'b0;
            write_q     <= 1'b0;
            data_out_q  <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        state_q     <= ST_SETUP;
                        we_q        <= cmd_we;
                        addr_q      <= cmd_addr;
                        cmd_ready_q <= 1'b0;
                        if (!cmd_we) begin
                            data_out_q <= arr_rdata;
                        end
                    end
                end
                ST_SETUP: begin
                    state_q <= ST_ACCESS;
                    cnt_q   <= ACC_INIT;
                    read_q  <= !we_q;
                    write_q <= we_q;
                end
                ST_ACCESS: begin
                    if (cnt_q == CNT_LAST) begin
                        state_q     <= ST_TURN;
                        cnt_q       <= '0;
                        read_q      <= 1'b0;
                        write_q     <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= !we_q && arr_perr;
                        if (!we_q) begin
                            rsp_data_q <= data_out_q;
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_TURN: begin
                    state_q     <= ST_IDLE;
                    rsp_valid_q <= 1'b0;
                    cmd_ready_q <= 1'b1;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign read      = read_q;
    assign write     = write_q;
    assign data_out  = data_out_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// tb/tb_mem_bus_ctrl.sv - self-checking bench for mem_bus_ctrl with a cycle-timeline reference model
module tb_mem_bus_ctrl;

    localparam int AW = 4;
    localparam int N  = 3;
`ifdef MEM_BUS_CTRL_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_we;
    logic [AW-1:0] cmd_addr;
    logic          read;
    logic          write;
    logic [7:0]    data_out;
    logic [7:0]    data_in;
    logic          rsp_valid;
    logic [7:0]    rsp_data;
    logic          rsp_err;

    int n_chk  = 0;
    int n_fail = 0;
    bit run_chk = 1'b0;

    always #5 clk = ~clk;

    mem_bus_ctrl #(
        .AW         (AW),
        .ACC_CYCLES (N)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_we    (cmd_we),
        .cmd_addr  (cmd_addr),
        .read      (read),
        .write     (write),
        .data_out  (data_out),
        .data_in   (data_in),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: m_k counts cycles since the accepting edge (1 = setup,
    // 2..N+1 = access, N+2 = turnaround, then idle again).
    logic [7:0]    m_mem [0:15];
    logic          m_busy;
    logic          m_we;
    int            m_k;
    logic [AW-1:0] m_addr;
    logic [7:0]    m_data_out;
    logic [7:0]    m_rsp_data;
    logic          m_rsp_err;
    bit            flip_on;
    logic [AW-1:0] flip_addr;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy     <= 1'b0;
            m_k        <= 0;
            m_data_out <= '0;
            m_rsp_data <= '0;
            m_rsp_err  <= 1'b0;
        end else if (!m_busy) begin
            if (cmd_valid) begin
                m_busy <= 1'b1;
                m_k    <= 1;
                m_we   <= cmd_we;
                m_addr <= cmd_addr;
                if (!cmd_we) m_data_out <= m_mem[cmd_addr];
            end
        end else begin
            if (m_k == N + 1) begin
                if (m_we) begin
                    m_mem[m_addr] <= data_in;
                    m_rsp_err     <= 1'b0;
                end else begin
                    m_rsp_data <= m_mem[m_addr];
                    m_rsp_err  <= PAR && flip_on && (m_addr == flip_addr);
                end
            end
            if (m_k == N + 2) begin
                m_busy <= 1'b0;
                m_k    <= 0;
            end else begin
                m_k <= m_k + 1;
            end
        end
    end

    always @(negedge clk) begin
        logic exp_acc;
        if (run_chk) begin
            exp_acc = m_busy && (m_k >= 2) && (m_k <= N + 1);
            chk("cmd_ready", cmd_ready, !m_busy);
            chk("read", read, exp_acc && !m_we);
            chk("write", write, exp_acc && m_we);
            chk("rsp_valid", rsp_valid, m_busy && (m_k == N + 2));
            chk("rsp_data", rsp_data, m_rsp_data);
            chk("no_overlap", read && write, 1'b0);
            if (m_busy && (m_k == N + 2)) chk("rsp_err", rsp_err, m_rsp_err);
            if (m_busy && !m_we) chk("data_out", data_out, m_data_out);
        end
    end

    task automatic run_cmd(input logic we, input logic [AW-1:0] addr,
                           input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2,
                           output int en_cnt, output int rsp_at, output logic rsp_e);
        int t = 0;
        en_cnt = 0;
        rsp_at = -1;
        rsp_e  = 1'b0;
        while (cmd_ready !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("ready_wait", t < 20, 1'b1);
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_addr  = addr;
        data_in   = d0;
        @(posedge clk);
        for (int k = 1; k <= N + 2; k++) begin
            @(negedge clk);
            if (k == 1) cmd_valid = 1'b0;
            if (k == 2) data_in = d0;
            else if (k == 3) data_in = d1;
            else if (k >= 4) data_in = d2;
            if (read || write) en_cnt++;
            if (rsp_valid) begin
                rsp_at = k;
                rsp_e  = rsp_err;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int         en, at, last_rd, first_wr;
        logic       e;
        logic [7:0] v;

        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_we    = 1'b0;
        cmd_addr  = '0;
        data_in   = '0;
        flip_on   = 1'b0;
        flip_addr = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_cmd_ready", cmd_ready, 1'b1);
        chk("rst_read", read, 1'b0);
        chk("rst_write", write, 1'b0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_data", rsp_data, 8'h00);
        chk("rst_data_out", data_out, 8'h00);
        chk("rst_rsp_err", rsp_err, 1'b0);
        run_chk = 1'b1;
        @(negedge clk);

        run_cmd(1'b1, 4'd3, 8'hA5, 8'hA5, 8'hA5, en, at, e);
        chk("t1_write_cycles", en, 3);
        chk("t1_write_latency", at, 5);
        run_cmd(1'b0, 4'd3, 8'h00, 8'h00, 8'h00, en, at, e);
        chk("t1_read_cycles", en, 3);
        chk("t1_read_latency", at, 5);
        chk("t1_rsp_data", rsp_data, 8'hA5);
        chk("t1_rsp_err", e, 1'b0);

        run_cmd(1'b1, 4'd0, 8'h11, 8'h22, 8'h33, en, at, e);
        chk("t2_write_cycles", en, 3);
        run_cmd(1'b0, 4'd0, 8'h00, 8'h00, 8'h00, en, at, e);
        chk("t2_last_beat", rsp_data, 8'h33);

        last_rd   = -1;
        first_wr  = -1;
        cmd_valid = 1'b1;
        cmd_we    = 1'b0;
        cmd_addr  = 4'd3;
        data_in   = 8'h77;
        @(posedge clk);
        for (int k = 1; k <= 2 * N + 6; k++) begin
            @(negedge clk);
            if (k == 1) begin
                cmd_we   = 1'b1;
                cmd_addr = 4'd9;
            end
            if (k == N + 4) cmd_valid = 1'b0;
            if (read) last_rd = k;
            if (write && first_wr < 0) first_wr = k;
        end
        chk("cv_last_read", last_rd, 4);
        chk("cv_first_write", first_wr, 8);
        chk("cv_gap", first_wr - last_rd - 1, 3);
        run_cmd(1'b0, 4'd9, 8'h00, 8'h00, 8'h00, en, at, e);
        chk("cv_write_data", rsp_data, 8'h77);

        run_cmd(1'b1, 4'd5, 8'h0F, 8'h0F, 8'h0F, en, at, e);
        cmd_valid = 1'b1;
        cmd_we    = 1'b1;
        cmd_addr  = 4'd5;
        data_in   = 8'hF0;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("rst_mid_write_on", write, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_write_drop", write, 1'b0);
        chk("rst_mid_read", read, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_mid_cmd_ready", cmd_ready, 1'b1);
        chk("rst_mid_rsp_valid", rsp_valid, 1'b0);
        chk("rst_mid_rsp_data", rsp_data, 8'h00);
        chk("rst_mid_data_out", data_out, 8'h00);
        chk("rst_mid_rsp_err", rsp_err, 1'b0);
        @(negedge clk);
        run_cmd(1'b0, 4'd5, 8'h00, 8'h00, 8'h00, en, at, e);
        chk("rst_mid_old_value", rsp_data, 8'h0F);

        for (int a = 0; a < 16; a++) begin
            v = 8'(a) ^ 8'h5A;
            run_cmd(1'b1, 4'(a), v, v, v, en, at, e);
        end
        for (int a = 0; a < 16; a++) begin
            run_cmd(1'b0, 4'(a), 8'h00, 8'h00, 8'h00, en, at, e);
            chk("sweep_read", rsp_data, 8'(a) ^ 8'h5A);
        end
        chk("sweep_last_addr", rsp_data, 8'h55);

        run_cmd(1'b0, 4'd4, 8'h00, 8'h00, 8'h00, en, at, e);
        chk("clean_rsp_err", e, 1'b0);
        chk("clean_rsp_data", rsp_data, 8'h5E);

`ifdef MEM_BUS_CTRL_PARITY_EN
        run_cmd(1'b1, 4'd7, 8'h80, 8'h80, 8'h80, en, at, e);
        dut.u_array.mem_q[7][8] = ~dut.u_array.mem_q[7][8];
        flip_addr = 4'd7;
        flip_on   = 1'b1;
        run_cmd(1'b0, 4'd7, 8'h00, 8'h00, 8'h00, en, at, e);
        chk("par_rsp_err", e, 1'b1);
        chk("par_rsp_data", rsp_data, 8'h80);
        flip_on = 1'b0;
`endif

        run_chk = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
